sys_state_ctrl: RTL and testbench
=================================

# sys_state_ctrl

System working-state controller for the ECT board. It accepts host commands over a valid/ready handshake and sequences the system through idle, self-check, acquisition work and fault. It drives the 2-bit `SysStat` code consumed directly by the LED indicator stage. It also issues the check-start pulse and the work enable to the measurement datapath, and counts completed frames.

## Interface
Parameters:
- `TIMEOUT`, default 20'd500000: self-check watchdog length in CLK1M cycles (0.5 s).
- `CNT_W`, default 20: watchdog timer width.

Ports:
- `CLK1M`  in  1  system clock, 1 MHz; all logic on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `CmdValid`  in  1  host command present.
- `CmdCode`  in  2  command: 00 NOP, 01 START_CHECK, 10 START_WORK, 11 STOP.
- `CmdData`  in  16  frame target for START_WORK; 0 means continuous.
- `CmdReady`  out  1  controller can accept a command.
- `CheckDone`  in  1  one-cycle pulse: self-check finished.
- `CheckPass`  in  1  self-check result; sampled only with `CheckDone`.
- `FrameDone`  in  1  one-cycle pulse: one acquisition frame completed.
- `SysStat`  out  2  state code: 00 Idle, 01 Check, 10 Work, 11 Fault.
- `CheckStart`  out  1  one-cycle pulse starting the self-check.
- `WorkEn`  out  1  acquisition enable.
- `FrameCnt`  out  16  frames completed in the current or last work run.
- `ErrFlag`  out  1  high while in Fault.
- `ErrCode`  out  2  fault cause: 01 work without a passed check, 10 check failed, 11 check timeout.

## Operation
- State register drives `SysStat` directly; `ErrFlag` = (state == Fault). `WorkEn` is registered and equals (state == Work).
- Handshake: a command is accepted on a rising edge where `CmdValid & CmdReady`. `CmdReady` = 0 in Check and 1 in every other state. NOP is accepted with no effect.
- Internal flag `CheckedOK` is set on a passed check and cleared by reset or by STOP from Fault.
- Idle:
  - START_CHECK -> Check, with the timer cleared and `CheckStart` pulsed.
  - START_WORK with `CheckedOK` -> Work, with `FrameCnt` cleared and the target latched from `CmdData`.
  - START_WORK without `CheckedOK` -> Fault, `ErrCode` = 01.
  - STOP -> stay in Idle.
- Check:
  - Timer increments each cycle.
  - `CheckDone & CheckPass` -> Idle, `CheckedOK` set.
  - `CheckDone & !CheckPass` -> Fault, `ErrCode` = 10.
  - Timer reaching TIMEOUT-1 with no `CheckDone` -> Fault, `ErrCode` = 11.
  - `CheckDone` in the timeout cycle wins over the timeout.
- Work:
  - `FrameDone` increments `FrameCnt`. In continuous mode the count saturates at 16'hFFFF.
  - With a nonzero target, the `FrameDone` that makes `FrameCnt` equal the target -> Idle.
  - STOP -> Idle; `FrameCnt` holds its value.
  - STOP and the final `FrameDone` in the same cycle: the count increments, then -> Idle.
  - START_CHECK and START_WORK are accepted and ignored.
- Fault:
  - Only STOP exits -> Idle, with `ErrCode` = 00 and `CheckedOK` cleared.
  - Other commands are accepted and ignored.
- Reset mid-operation: every register returns to its reset value immediately, regardless of state.

## Timing
- Reset values:
  - `SysStat` = 00, `CheckStart` = 0, `WorkEn` = 0, `FrameCnt` = 0, `ErrFlag` = 0, `ErrCode` = 00.
  - `CmdReady` = 1, `CheckedOK` = 0, timer = 0.
- Command to state change: 1 cycle. `SysStat`, `WorkEn` and `CheckStart` update on the same edge that accepts the command.
- `CheckStart` is high exactly one cycle: the first cycle of Check.
- Watchdog: Check is held for exactly TIMEOUT cycles before Fault.
- `CheckDone` or `FrameDone` to the resulting state or count change: 1 cycle.
- `FrameDone` is ignored outside Work; `CheckDone` is ignored outside Check.

## Configuration
- `SYS_WATCHDOG_EN` defined: check timeout active as described; `ErrCode` 11 is reachable.
- `SYS_WATCHDOG_EN` undefined: no timer is built; Check waits indefinitely for `CheckDone`, and `ErrCode` 11 is never produced.

## Test plan
- Reset, then START_CHECK, then `CheckDone` with `CheckPass`=1 after 100 cycles -> `SysStat` 00->01->00, one `CheckStart` pulse, `CmdReady` = 0 during Check.
- After a passed check, START_WORK with `CmdData`=3 plus three `FrameDone` pulses -> `WorkEn` high for the run, `FrameCnt` = 3, `SysStat` back to 00 one cycle after the third pulse.
- START_WORK from reset without a check -> `SysStat` = 11, `ErrCode` = 01; then STOP -> `SysStat` = 00, `ErrCode` = 00.
- START_CHECK with no `CheckDone` (macro defined, TIMEOUT=16) -> Fault after exactly 16 cycles, `ErrCode` = 11. `CheckDone` with `CheckPass`=1 in cycle 16 -> Idle instead.
- Continuous work (`CmdData`=0), STOP in the same cycle as a `FrameDone` -> `FrameCnt` incremented, `SysStat` = 00.
- Assert `RST` low mid-Work with `FrameCnt`=5 -> all outputs at their reset values immediately, `CheckedOK` cleared, so START_WORK then goes to Fault.

Source files
------------

// File: rtl/sys_state_ctrl.sv
// sys_state_ctrl: system working-state controller for the ECT board.
// Accepts host commands over a valid/ready handshake and sequences the
// system through Idle, Check (self-check), Work (acquisition) and Fault.
// SysStat is the raw state code consumed by the LED indicator stage.
// Optional feature: define SYS_WATCHDOG_EN to build the self-check
// watchdog timer (ErrCode 11 on timeout); without it Check waits
// indefinitely for CheckDone.
module sys_state_ctrl #(
    parameter int unsigned      CNT_W   = 20,
    parameter logic [CNT_W-1:0] TIMEOUT = 20'd500000
) (
    input  logic        CLK1M,
    input  logic        RST,
    input  logic        CmdValid,
    input  logic [1:0]  CmdCode,
    input  logic [15:0] CmdData,
    output logic        CmdReady,
    input  logic        CheckDone,
    input  logic        CheckPass,
    input  logic        FrameDone,
    output logic [1:0]  SysStat,
    output logic        CheckStart,
    output logic        WorkEn,
    output logic [15:0] FrameCnt,
    output logic        ErrFlag,
    output logic [1:0]  ErrCode
);

    // State encoding doubles as the LED status code.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CHECK = 2'b01,
        ST_WORK  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        CMD_NOP         = 2'b00,
        CMD_START_CHECK = 2'b01,
        CMD_START_WORK  = 2'b10,
        CMD_STOP        = 2'b11
    } cmd_t;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_NO_CHECK   = 2'b01;
    localparam logic [1:0] ERR_CHECK_FAIL = 2'b10;
`ifdef SYS_WATCHDOG_EN
    localparam logic [1:0] ERR_TIMEOUT    = 2'b11;
    // Last timer value of the watchdog window; Check lasts TIMEOUT cycles.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT - CNT_W'(1);
`endif

    state_t      state, state_nxt;
    logic        check_start_nxt;
    logic        checked_ok, checked_ok_nxt;
    logic [15:0] frame_cnt_nxt;
    logic [15:0] frame_inc;
    logic [15:0] target, target_nxt;
    logic [1:0]  err_code_nxt;
    logic        cmd_fire;
    cmd_t        cmd;

`ifdef SYS_WATCHDOG_EN
    logic [CNT_W-1:0] timer, timer_nxt;
`else
    // Timer parameters have no hardware in this build; this empty block
    // only keeps them referenced.
    if (CNT_W == 0 || TIMEOUT == '0) begin : g_unused_timer_params
    end
`endif

    // Combinational status outputs decoded from the state register.
    assign SysStat  = state;
    assign ErrFlag  = (state == ST_FAULT);
    assign CmdReady = (state != ST_CHECK);
    assign cmd_fire = CmdValid & CmdReady;
    assign cmd      = cmd_t'(CmdCode);
    // Count saturates at all-ones; only reachable in continuous mode.
    assign frame_inc = (FrameCnt == 16'hFFFF) ? FrameCnt : FrameCnt + 16'd1;

    // Next-state and next-register-value logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_nxt       = state;
        check_start_nxt = 1'b0;
        checked_ok_nxt  = checked_ok;
        frame_cnt_nxt   = FrameCnt;
        target_nxt      = target;
        err_code_nxt    = ErrCode;
`ifdef SYS_WATCHDOG_EN
        timer_nxt       = timer;
`endif
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (cmd)
                        CMD_START_CHECK: begin
                            state_nxt       = ST_CHECK;
                            check_start_nxt = 1'b1;
`ifdef SYS_WATCHDOG_EN
                            timer_nxt       = '0;
`endif
                        end
                        CMD_START_WORK: begin
                            if (checked_ok) begin
                                state_nxt     = ST_WORK;
                                frame_cnt_nxt = 16'd0;
                                target_nxt    = CmdData;
                            end else begin
                                state_nxt     = ST_FAULT;
                                err_code_nxt  = ERR_NO_CHECK;
                            end
                        end
                        default: ;  // NOP and STOP leave Idle unchanged
                    endcase
                end
            end
            ST_CHECK: begin
`ifdef SYS_WATCHDOG_EN
                timer_nxt = timer + CNT_W'(1);
`endif
                // CheckDone takes priority over a coincident timeout.
                if (CheckDone) begin
                    if (CheckPass) begin
                        state_nxt      = ST_IDLE;
                        checked_ok_nxt = 1'b1;
                    end else begin
                        state_nxt      = ST_FAULT;
                        err_code_nxt   = ERR_CHECK_FAIL;
                    end
                end
`ifdef SYS_WATCHDOG_EN
                else if (timer == TIMEOUT_LAST) begin
                    state_nxt    = ST_FAULT;
                    err_code_nxt = ERR_TIMEOUT;
                end
`endif
            end
            ST_WORK: begin
                if (FrameDone) begin
                    frame_cnt_nxt = frame_inc;
                    if (target != 16'd0 && frame_inc == target) begin
                        state_nxt = ST_IDLE;
                    end
                end
                // STOP ends the run; a coincident frame still counts.
                if (cmd_fire && cmd == CMD_STOP) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (cmd_fire && cmd == CMD_STOP) begin
                    state_nxt      = ST_IDLE;
                    err_code_nxt   = ERR_NONE;
                    checked_ok_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge CLK1M or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            CheckStart <= 1'b0;
            WorkEn     <= 1'b0;
            FrameCnt   <= 16'd0;
            ErrCode    <= ERR_NONE;
            checked_ok <= 1'b0;
            target     <= 16'd0;
`ifdef SYS_WATCHDOG_EN
            timer      <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_nxt;
            CheckStart <= check_start_nxt;
            WorkEn     <= (state_nxt == ST_WORK);
            FrameCnt   <= frame_cnt_nxt;
            ErrCode    <= err_code_nxt;
            checked_ok <= checked_ok_nxt;
            target     <= target_nxt;
`ifdef SYS_WATCHDOG_EN
            timer      <= timer_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sys_state_ctrl.sv
// tb_sys_state_ctrl: self-checking bench for sys_state_ctrl.
// A behavioural model predicts every output after each clock edge; the
// prediction is queued when stimulus is driven and popped and compared
// once the DUT has updated. Watchdog expectations follow SYS_WATCHDOG_EN.
`timescale 1ns/1ps
module tb_sys_state_ctrl;

    localparam int TB_TIMEOUT = 16;
`ifdef SYS_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    localparam int CHECK_WAIT = WD ? 10 : 100;

    logic        clk1m = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_code;
    logic [15:0] cmd_data;
    logic        cmd_ready;
    logic        check_done;
    logic        check_pass;
    logic        frame_done;
    logic [1:0]  sys_stat;
    logic        check_start;
    logic        work_en;
    logic [15:0] frame_cnt;
    logic        err_flag;
    logic [1:0]  err_code;

    sys_state_ctrl #(
        .CNT_W   (20),
        .TIMEOUT (20'd16)
    ) dut (
        .CLK1M      (clk1m),
        .RST        (rst),
        .CmdValid   (cmd_valid),
        .CmdCode    (cmd_code),
        .CmdData    (cmd_data),
        .CmdReady   (cmd_ready),
        .CheckDone  (check_done),
        .CheckPass  (check_pass),
        .FrameDone  (frame_done),
        .SysStat    (sys_stat),
        .CheckStart (check_start),
        .WorkEn     (work_en),
        .FrameCnt   (frame_cnt),
        .ErrFlag    (err_flag),
        .ErrCode    (err_code)
    );

    // 1 MHz clock
    always #500 clk1m = ~clk1m;

    typedef struct {
        logic [1:0]  stat;
        logic        ready;
        logic        cs;
        logic        we;
        logic [15:0] cnt;
        logic        eflag;
        logic [1:0]  ecode;
    } exp_t;

    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cs_seen  = 0;
    string phase    = "reset";

    // Reference model state
    logic [1:0]  m_state;
    bit          m_ok;
    int          m_timer;
    logic [15:0] m_target;
    logic [15:0] m_cnt;
    logic [1:0]  m_err;
    logic        m_cs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %0h expected %0h (t=%0t)", phase, tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 2'b00; m_ok = 1'b0; m_timer = 0;
        m_target = 16'd0; m_cnt = 16'd0; m_err = 2'b00; m_cs = 1'b0;
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_step();
        bit fire;
        int t;
        fire = cmd_valid && (m_state != 2'b01);
        m_cs = 1'b0;
        case (m_state)
            2'b00: if (fire) begin
                if (cmd_code == 2'b01) begin
                    m_state = 2'b01; m_timer = 0; m_cs = 1'b1;
                end else if (cmd_code == 2'b10) begin
                    if (m_ok) begin m_state = 2'b10; m_cnt = 16'd0; m_target = cmd_data; end
                    else begin m_state = 2'b11; m_err = 2'b01; end
                end
            end
            2'b01: begin
                t = m_timer;
                m_timer++;
                if (check_done) begin
                    if (check_pass) begin m_state = 2'b00; m_ok = 1'b1; end
                    else begin m_state = 2'b11; m_err = 2'b10; end
                end else if (WD && t == TB_TIMEOUT - 1) begin
                    m_state = 2'b11; m_err = 2'b11;
                end
            end
            2'b10: begin
                if (frame_done) begin
                    if (m_cnt != 16'hFFFF) m_cnt++;
                    if (m_target != 16'd0 && m_cnt == m_target) m_state = 2'b00;
                end
                if (fire && cmd_code == 2'b11) m_state = 2'b00;
            end
            default: if (fire && cmd_code == 2'b11) begin
                m_state = 2'b00; m_err = 2'b00; m_ok = 1'b0;
            end
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.stat  = m_state;
        e.ready = (m_state != 2'b01);
        e.cs    = m_cs;
        e.we    = (m_state == 2'b10);
        e.cnt   = m_cnt;
        e.eflag = (m_state == 2'b11);
        e.ecode = m_err;
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("SysStat",    sys_stat,    e.stat);
            check("CmdReady",   cmd_ready,   e.ready);
            check("CheckStart", check_start, e.cs);
            check("WorkEn",     work_en,     e.we);
            check("FrameCnt",   frame_cnt,   e.cnt);
            check("ErrFlag",    err_flag,    e.eflag);
            check("ErrCode",    err_code,    e.ecode);
        end
    endtask

    // One clock: predict, queue, let the DUT clock, then compare.
    task automatic step();
        model_step();
        sb_q.push_back(model_out());
        @(posedge clk1m);
        #1;
        compare_out();
        if (check_start) cs_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_cmd(input logic [1:0] code, input logic [15:0] data);
        cmd_valid = 1'b1; cmd_code = code; cmd_data = data;
        step();
        cmd_valid = 1'b0; cmd_code = 2'b00; cmd_data = 16'd0;
    endtask

    task automatic pulse_check(input logic pass);
        check_done = 1'b1; check_pass = pass;
        step();
        check_done = 1'b0; check_pass = 1'b0;
    endtask

    task automatic pulse_frame(input logic with_stop);
        frame_done = 1'b1;
        if (with_stop) begin cmd_valid = 1'b1; cmd_code = 2'b11; end
        step();
        frame_done = 1'b0; cmd_valid = 1'b0; cmd_code = 2'b00;
    endtask

    // Global time limit so the bench always terminates.
    initial begin
        #50_000_000;
        $display("FAIL time_limit: simulation still running at %0t", $time);
        $fatal(1, "time limit expired");
    end

    initial begin
        int in_check;
        rst = 1'b0; cmd_valid = 1'b0; cmd_code = 2'b00; cmd_data = 16'd0;
        check_done = 1'b0; check_pass = 1'b0; frame_done = 1'b0;
        model_reset();
        repeat (3) @(posedge clk1m);
        @(negedge clk1m);
        rst = 1'b1;
        sb_q.push_back(model_out());
        compare_out();

        // START_WORK without a passed check -> Fault 01, STOP clears it.
        phase = "no_check";
        send_cmd(2'b10, 16'd4);
        send_cmd(2'b01, 16'd0);      // ignored in Fault
        send_cmd(2'b11, 16'd0);
        idle(2);

        // Passed self-check; a command offered during Check is not accepted.
        phase = "check_pass";
        cs_seen = 0;
        send_cmd(2'b01, 16'd0);
        idle(3);
        send_cmd(2'b10, 16'd7);
        idle(CHECK_WAIT - 4);
        pulse_check(1'b1);
        check("check_start_pulses", cs_seen, 1);
        pulse_frame(1'b0);           // FrameDone outside Work ignored
        idle(1);

        // Targeted run of three frames.
        phase = "work3";
        send_cmd(2'b10, 16'd3);
        pulse_frame(1'b0);
        idle(2);
        send_cmd(2'b01, 16'd0);      // ignored in Work
        pulse_frame(1'b0);
        idle(1);
        pulse_frame(1'b0);
        check("frames_done", frame_cnt, 16'd3);
        check("idle_after_target", sys_stat, 2'b00);
        pulse_check(1'b1);           // CheckDone outside Check ignored
        idle(1);

        // Continuous run ended by STOP coinciding with a frame.
        phase = "continuous";
        send_cmd(2'b10, 16'd0);
        pulse_frame(1'b0);
        pulse_frame(1'b0);
        pulse_frame(1'b1);
        check("stop_with_frame_cnt", frame_cnt, 16'd3);
        idle(1);

        // STOP alone holds the count.
        phase = "stop_hold";
        send_cmd(2'b10, 16'd5);
        pulse_frame(1'b0);
        pulse_frame(1'b0);
        send_cmd(2'b11, 16'd0);
        idle(2);

        // Failed check -> Fault 10.
        phase = "check_fail";
        send_cmd(2'b01, 16'd0);
        idle(2);
        pulse_check(1'b0);
        send_cmd(2'b11, 16'd0);

        // Watchdog window length (or indefinite wait without it).
        phase = "timeout";
        send_cmd(2'b01, 16'd0);
        in_check = 1;
        while (sys_stat == 2'b01 && in_check < 40) begin
            step();
            if (sys_stat == 2'b01) in_check++;
        end
        check("check_cycles", in_check, WD ? TB_TIMEOUT : 40);
        if (sys_stat == 2'b01) pulse_check(1'b1);
        send_cmd(2'b11, 16'd0);

        // CheckDone in the final watchdog cycle wins.
        phase = "done_at_limit";
        send_cmd(2'b01, 16'd0);
        idle(TB_TIMEOUT - 1);
        pulse_check(1'b1);
        check("limit_done_idle", sys_stat, 2'b00);
        idle(1);

        // Asynchronous reset mid-Work with FrameCnt = 5.
        phase = "mid_reset";
        send_cmd(2'b10, 16'd0);
        for (int i = 0; i < 5; i++) pulse_frame(1'b0);
        check("cnt_before_reset", frame_cnt, 16'd5);
        #200 rst = 1'b0;
        #1;
        model_reset();
        sb_q.push_back(model_out());
        compare_out();
        #100 rst = 1'b1;
        send_cmd(2'b10, 16'd2);      // checked flag lost -> Fault 01
        send_cmd(2'b11, 16'd0);
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
